// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants and helpers for the multichannel PWM block.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Counting-mode encodings as seen on the center_mode input
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Width of a channel index; never narrower than one bit
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module   : pwm_timebase
// Purpose  : Shared PWM timebase: prescaler, up / up-down main counter,
//            mode-change restart and the period-boundary pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int RES   = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PRE_W-1:0] i_prescale,
  input  logic             i_center_mode,
  output logic [RES-1:0]   o_counter,
  output logic             o_boundary
);

  // Highest counter value reached in either mode (MAX-1)
  localparam logic [RES-1:0] C_TOP  = {{(RES-1){1'b1}}, 1'b0};
  localparam logic [RES-1:0] C_ZERO = '0;

  // Count-direction state encoding
  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;

  logic [PRE_W-1:0] r_pre;
  logic [RES-1:0]   r_cnt;
  logic [RES-1:0]   w_cnt_nxt;
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_mode;
  logic             r_boundary;
  logic             w_mode_chg;
  logic             w_tick;
  logic             w_reload;
  logic             w_count_down;

  // A mode flip is detected against the registered copy of the mode input
  assign w_mode_chg = (i_center_mode != r_mode);
  // Tick on the last prescaler count; a count stranded above a lowered
  // prescale value is discarded without producing a tick
  assign w_tick     = (r_pre == i_prescale);
  assign w_reload   = (r_pre > i_prescale);

  assign o_counter  = r_cnt;
  assign o_boundary = r_boundary;

  // Prescaler: 0..prescale, restarting on tick, reload or mode change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_mode_chg || w_tick || w_reload) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Direction state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction next state: turn around on the tick that lands on a turning point
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg || (r_mode == MODE_EDGE)) begin
      w_state_nxt = ST_UP;
    end else if (w_tick) begin
      if (w_cnt_nxt == C_TOP) begin
        w_state_nxt = ST_DOWN;
      end else if (w_cnt_nxt == C_ZERO) begin
        w_state_nxt = ST_UP;
      end
    end
  end

  // Direction output decode
  always_comb begin
    w_count_down = (r_state == ST_DOWN);
  end

  // Counter value taken on the next tick
  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    if (r_mode == MODE_CENTER) begin
      if (w_count_down) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end else if (r_cnt == C_TOP) begin
      w_cnt_nxt = C_ZERO;
    end
  end

  // Main counter and boundary flag; the flag is high in the first cycle at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_boundary <= 1'b0;
      r_mode     <= MODE_EDGE;
    end else begin
      r_mode <= i_center_mode;
      if (w_mode_chg) begin
        r_cnt      <= '0;
        r_boundary <= 1'b1;
      end else if (w_tick) begin
        r_cnt      <= w_cnt_nxt;
        r_boundary <= (w_cnt_nxt == C_ZERO);
      end else begin
        r_boundary <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multichannel
// Purpose  : NUM_CH-channel PWM with shared prescaled timebase, edge/center
//            alignment and double-buffered duty registers.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int RES    = 8,
  parameter int PRE_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             i_en_out,
  input  logic [NUM_CH-1:0]             i_en_pwm,
  input  logic [PRE_W-1:0]              i_prescale,
  input  logic                          i_center_mode,
  input  logic                          i_duty_wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0]   i_duty_wr_ch,
  input  logic [RES-1:0]                i_duty_wr_data,
  output logic [NUM_CH-1:0]             o_out,
  output logic                          o_period_start
);

  localparam int             CH_W   = ch_idx_w(NUM_CH);
  localparam logic [RES-1:0] C_MAX  = '1;
  localparam logic [RES-1:0] C_ZERO = '0;

  logic [RES-1:0]    w_counter;
  logic              w_boundary;
  logic [NUM_CH-1:0] w_out_nxt;

  pwm_timebase #(
    .RES   (RES),
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_prescale    (i_prescale),
    .i_center_mode (i_center_mode),
    .o_counter     (w_counter),
    .o_boundary    (w_boundary)
  );

  // The boundary flag is already a register output
  assign o_period_start = w_boundary;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [RES-1:0] r_shadow;
    logic [RES-1:0] r_active;
    logic [RES-1:0] w_shadow_nxt;
    logic [RES-1:0] w_active_nxt;
    logic           w_wr_hit;
    logic           w_pwm;

    // Only existing channels decode, so out-of-range indices write nothing
    assign w_wr_hit = i_duty_wr_en && (i_duty_wr_ch == CH_W'(g));

    // Duty selection and compare; the compare sees the value being loaded so a
    // new duty applies from the very first count of its period
    always_comb begin
      w_shadow_nxt = w_wr_hit ? i_duty_wr_data : r_shadow;
      w_active_nxt = (w_boundary || !i_en_pwm[g]) ? w_shadow_nxt : r_active;
      if (w_active_nxt == C_MAX) begin
        w_pwm = 1'b1;
      end else if (w_active_nxt == C_ZERO) begin
        w_pwm = 1'b0;
      end else begin
        w_pwm = (w_counter < w_active_nxt);
      end
    end

    // Shadow and active duty registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        r_shadow <= w_shadow_nxt;
        r_active <= w_active_nxt;
      end
    end

    // Static-high when PWM is disabled, forced low when the output is disabled
    assign w_out_nxt[g] = i_en_out[g] & (~i_en_pwm[g] | w_pwm);
  end

  // Output pin register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out <= '0;
    end else begin
      o_out <= w_out_nxt;
    end
  end

endmodule
`default_nettype wire
